// File: rtl/stream_fifo_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : stream_fifo_buffer
//  Description : Single-clock valid/ready FIFO with first-word-fall-through
//                output, fill level, almost-full flag and synchronous flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_fifo_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 4,
  parameter int ALMOST_FULL = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         i_valid,
  output logic                         i_ready,
  input  logic [DATA_WIDTH-1:0]        i_data,
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         almost_full
);

  // Pointers carry one extra wrap bit. For a power-of-two DEPTH the pointer
  // difference then spans 0..DEPTH exactly and serves as the fill level, so
  // no separate counter can drift out of step with the pointers.
  localparam int c_aw = $clog2(DEPTH);
  localparam int c_pw = c_aw + 1;
  localparam logic [c_pw-1:0] c_depth_lvl = c_pw'(DEPTH);
  localparam logic [c_pw-1:0] c_af_lvl    = c_pw'(ALMOST_FULL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [c_pw-1:0]       wr_ptr_q;
  logic [c_pw-1:0]       wr_ptr_d;
  logic [c_pw-1:0]       rd_ptr_q;
  logic [c_pw-1:0]       rd_ptr_d;
  logic                  ready_q;
  logic                  ready_d;
  logic [c_pw-1:0]       w_level;
  logic [c_pw-1:0]       w_level_d;
  logic                  w_push;
  logic                  w_pop;

  assign w_level = wr_ptr_q - rd_ptr_q;

  // Flush blanks both handshakes in its cycle so nothing is accepted or
  // delivered while the contents are being discarded. i_ready deliberately
  // ignores o_ready: a full FIFO never accepts, even while it is being read.
  assign i_ready = ready_q & ~flush;
  assign o_valid = (w_level != '0) & ~flush;
  assign w_push  = i_valid & i_ready;
  assign w_pop   = o_valid & o_ready;

  assign o_data      = o_valid ? mem_q[rd_ptr_q[c_aw-1:0]] : '0;
  assign level       = w_level;
  assign almost_full = (w_level >= c_af_lvl);

  // Next pointers and the registered-ready lookahead from the next level
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + c_pw'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + c_pw'(1);
    end
    w_level_d = wr_ptr_d - rd_ptr_d;
    ready_d   = flush | (w_level_d < c_depth_lvl);
  end

  // Pointer and ready state; ready stays low until the first edge after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ready_d;
    end
  end

  // Storage array is not reset; validity comes only from the pointers
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q[c_aw-1:0]] <= i_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_fifo_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_fifo_buffer
//  Description : Self-checking bench for stream_fifo_buffer (DEPTH=4, 8-bit)
//                using a queue-based reference model and directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_fifo_buffer;

  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int AF = DEPTH - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic [DW-1:0] i_data = '0;
  logic          o_valid;
  logic          o_ready = 1'b0;
  logic [DW-1:0] o_data;
  logic [2:0]    level;
  logic          almost_full;

  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  logic [DW-1:0] mq[$];
  logic          m_rdy = 1'b0;
  logic [DW-1:0] popped[$];
  logic [DW-1:0] exp_q[$];

  stream_fifo_buffer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ALMOST_FULL(AF)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .i_data     (i_data),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .level      (level),
    .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare outputs against the model mid-cycle, then advance the model
  // to what the coming rising edge must do.
  logic          e_ir;
  logic          e_ov;
  logic [DW-1:0] e_od;
  always @(negedge clk) begin
    if (!reset_n) begin
      mq.delete();
      m_rdy = 1'b0;
    end
    e_ir = m_rdy & ~flush;
    e_ov = (mq.size() != 0) & ~flush;
    e_od = e_ov ? mq[0] : '0;
    chk("m_i_ready", 32'(i_ready), 32'(e_ir));
    chk("m_o_valid", 32'(o_valid), 32'(e_ov));
    chk("m_o_data", 32'(o_data), 32'(e_od));
    chk("m_level", 32'(level), 32'(mq.size()));
    chk("m_almost_full", 32'(almost_full), 32'(mq.size() >= AF));
    if (reset_n) begin
      if (flush) begin
        mq.delete();
        m_rdy = 1'b1;
      end else begin
        if (e_ov && o_ready) begin
          popped.push_back(o_data);
          void'(mq.pop_front());
        end
        if (i_valid && e_ir) mq.push_back(i_data);
        m_rdy = (mq.size() < DEPTH);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold the current i_valid/i_data until an edge accepts it
  task automatic wait_accept();
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      acc = i_ready;
      step();
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic push(input logic [DW-1:0] d);
    i_valid = 1'b1;
    i_data  = d;
    wait_accept();
    i_valid = 1'b0;
  endtask

  task automatic drain();
    o_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (!o_valid) break;
    end
    chk("drain_empty", 32'(o_valid), 32'd0);
    o_ready = 1'b0;
  endtask

  task automatic check_popped(input string nm);
    chk({nm, "_count"}, 32'(popped.size()), 32'(exp_q.size()));
    for (int k = 0; k < popped.size() && k < exp_q.size(); k++)
      chk({nm, "_word"}, 32'(popped[k]), 32'(exp_q[k]));
    popped.delete();
  endtask

  initial begin
    // 1: reset
    step();
    chk("rst_i_ready", 32'(i_ready), 32'd0);
    chk("rst_o_data", 32'(o_data), 32'd0);
    step();
    reset_n = 1'b1;
    chk("rel_i_ready_low", 32'(i_ready), 32'd0);
    chk("rel_level", 32'(level), 32'd0);
    step();
    chk("rel_i_ready_high", 32'(i_ready), 32'd1);
    chk("rel_o_valid", 32'(o_valid), 32'd0);

    // 2: ordered pass-through with fill-level and almost-full tracking
    push(8'h12);
    chk("p2_level1", 32'(level), 32'd1);
    chk("p2_af1", 32'(almost_full), 32'd0);
    push(8'h55);
    chk("p2_level2", 32'(level), 32'd2);
    chk("p2_af2", 32'(almost_full), 32'd0);
    push(8'h88);
    chk("p2_level3", 32'(level), 32'd3);
    chk("p2_af3", 32'(almost_full), 32'd1);
    push(8'hdd);
    chk("p2_level4", 32'(level), 32'd4);
    chk("p2_full_i_ready", 32'(i_ready), 32'd0);
    chk("p2_head", 32'(o_data), 32'h12);
    drain();
    chk("p2_level_end", 32'(level), 32'd0);
    exp_q = '{8'h12, 8'h55, 8'h88, 8'hdd};
    check_popped("p2_order");

    // 3: full FIFO refuses a push even while being read
    push(8'h12);
    push(8'h55);
    push(8'h88);
    push(8'hdd);
    i_valid = 1'b1;
    i_data  = 8'hee;
    o_ready = 1'b1;
    step();
    o_ready = 1'b0;
    chk("p3_level_after_pop", 32'(level), 32'd3);
    chk("p3_head", 32'(o_data), 32'h55);
    wait_accept();
    i_valid = 1'b0;
    chk("p3_level_after_push", 32'(level), 32'd4);
    drain();
    exp_q = '{8'h12, 8'h55, 8'h88, 8'hdd, 8'hee};
    check_popped("p3_order");

    // 4: continuous streaming of 64 words
    o_ready = 1'b1;
    i_valid = 1'b1;
    exp_q.delete();
    for (int d = 0; d < 64; d++) begin
      i_data = DW'(d);
      exp_q.push_back(DW'(d));
      wait_accept();
      if (d == 32) chk("p4_level_steady", 32'(level), 32'd1);
    end
    i_valid = 1'b0;
    drain();
    check_popped("p4_stream");

    // 5: flush discards stored words and blocks both handshakes
    push(8'h12);
    push(8'h55);
    push(8'h88);
    flush   = 1'b1;
    i_valid = 1'b1;
    i_data  = 8'h77;
    o_ready = 1'b1;
    #1;
    chk("p5_flush_i_ready", 32'(i_ready), 32'd0);
    chk("p5_flush_o_valid", 32'(o_valid), 32'd0);
    step();
    flush   = 1'b0;
    i_valid = 1'b0;
    o_ready = 1'b0;
    chk("p5_level_after", 32'(level), 32'd0);
    chk("p5_o_valid_after", 32'(o_valid), 32'd0);
    push(8'haa);
    chk("p5_head", 32'(o_data), 32'haa);
    drain();
    exp_q = '{8'haa};
    check_popped("p5_after_flush");

    // 6: asynchronous reset in the middle of operation
    push(8'h01);
    push(8'h02);
    push(8'h03);
    chk("p6_level_before", 32'(level), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("p6_o_valid", 32'(o_valid), 32'd0);
    chk("p6_i_ready", 32'(i_ready), 32'd0);
    chk("p6_level", 32'(level), 32'd0);
    chk("p6_o_data", 32'(o_data), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();
    chk("p6_ready_back", 32'(i_ready), 32'd1);
    chk("p6_still_empty", 32'(o_valid), 32'd0);
    popped.delete();

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
